// File: rtl/start_pulse_gen.sv
// -----------------------------------------------------------------------------
// start_pulse_gen
//
// Purpose:
//   Turns a raw, asynchronous push-button level into one clean, fixed-width
//   START pulse per press for the sequencing FSM downstream. The button is
//   synchronised, debounced, and re-triggering is blocked until a hold-off
//   period has passed and a debounced release has been observed.
//
// Parameters:
//   SYNC_STAGES     flops in the input synchroniser chain (>=2)
//   DEBOUNCE_CYCLES consecutive stable samples required for press/release (>=1)
//   PULSE_CYCLES    START high time in CLK cycles (>=1)
//   HOLDOFF_CYCLES  dead time after the pulse, input ignored (0 = no hold-off)
//   CNT_W           shared counter width, must hold the largest of the counts
//
// Ports:
//   CLK        in   system clock, all logic on posedge
//   RST_N      in   asynchronous, active-low reset
//   BTN_IN     in   raw button level, asynchronous to CLK, active high
//   ENABLE     in   arms press detection; low = new presses ignored
//   START      out  debounced start pulse (decoded from the state register)
//   BUSY       out  high in every state except IDLE
//   PRESS_CNT  out  8-bit count of emitted pulses, wraps 255 -> 0
// -----------------------------------------------------------------------------
module start_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 1,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_IN,
  input  logic       ENABLE,
  output logic       START,
  output logic       BUSY,
  output logic [7:0] PRESS_CNT
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    DEBOUNCE     = 3'd1,
    PULSE        = 3'd2,
    HOLDOFF      = 3'd3,
    WAIT_RELEASE = 3'd4
  } state_t;

  // Terminal counts for the shared counter. HOLD_LAST is never compared
  // against when HOLDOFF_CYCLES is 0, so its wrapped value is harmless.
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   btn_s;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [7:0]             press_cnt_reg, press_cnt_next;

  // Synchroniser: BTN_IN enters at bit 0, btn_s is the last flop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], BTN_IN};
    end
  end

  assign btn_s = sync_reg[SYNC_STAGES-1];

  // State, shared counter and press counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      press_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      press_cnt_reg <= press_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    press_cnt_next = press_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (ENABLE && btn_s) begin
          state_next = DEBOUNCE;
          cnt_next   = '0;
        end
      end

      DEBOUNCE: begin
        if (!btn_s || !ENABLE) begin
          // Any bounce or disarm restarts the whole press from IDLE.
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          // Count the press on the same edge START rises.
          state_next     = PULSE;
          cnt_next       = '0;
          press_cnt_next = press_cnt_reg + 8'd1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      PULSE: begin
        // ENABLE and the button are deliberately ignored: only reset can
        // shorten a pulse that has started.
        if (cnt_reg == PULSE_LAST) begin
          state_next = (HOLDOFF_CYCLES == 0) ? WAIT_RELEASE : HOLDOFF;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      HOLDOFF: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = WAIT_RELEASE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      WAIT_RELEASE: begin
        // A held (or bouncing-high) button keeps restarting the release count.
        if (btn_s) begin
          cnt_next = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pure decodes of the state register, so they clear the moment reset hits.
  assign START     = (state_reg == PULSE);
  assign BUSY      = (state_reg != IDLE);
  assign PRESS_CNT = press_cnt_reg;

endmodule

// File: tb/tb_start_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_start_pulse_gen
//
// Directed bench for start_pulse_gen. Three instances share the same inputs:
//   u_dut0 : default parameters
//   u_dut1 : PULSE_CYCLES = 4
//   u_dut2 : HOLDOFF_CYCLES = 0, PULSE_CYCLES = 3
// Edge numbering: the first rising edge after the button is driven high is
// edge 1; outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_start_pulse_gen;

  logic       CLK;
  logic       RST_N;
  logic       BTN_IN;
  logic       ENABLE;

  logic       start0, busy0;
  logic [7:0] cnt0;
  logic       start1, busy1;
  logic [7:0] cnt1;
  logic       start2, busy2;
  logic [7:0] cnt2;

  int tests = 0;
  int fails = 0;
  int npulse;

  start_pulse_gen u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .BTN_IN(BTN_IN), .ENABLE(ENABLE),
    .START(start0), .BUSY(busy0), .PRESS_CNT(cnt0)
  );

  start_pulse_gen #(.PULSE_CYCLES(4)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .BTN_IN(BTN_IN), .ENABLE(ENABLE),
    .START(start1), .BUSY(busy1), .PRESS_CNT(cnt1)
  );

  start_pulse_gen #(.HOLDOFF_CYCLES(0), .PULSE_CYCLES(3)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .BTN_IN(BTN_IN), .ENABLE(ENABLE),
    .START(start2), .BUSY(busy2), .PRESS_CNT(cnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N  = 1'b0;
    BTN_IN = 1'b0;
    ENABLE = 1'b1;
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    RST_N  = 1'b0;
    BTN_IN = 1'b0;
    ENABLE = 1'b1;
    #1;
    chk1("reset_start", start0, 1'b0);
    chk1("reset_busy", busy0, 1'b0);
    chk8("reset_cnt", cnt0, 8'd0);

    // ---- Reset mid-pulse (4-cycle pulse instance) ----
    do_reset();
    BTN_IN = 1'b1;
    for (int e = 1; e <= 20; e++) tick();
    chk1("rstmid_start_before", start1, 1'b1);
    chk8("rstmid_cnt_before", cnt1, 8'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk1("rstmid_start_async", start1, 1'b0);
    chk1("rstmid_busy_async", busy1, 1'b0);
    chk8("rstmid_cnt_async", cnt1, 8'd0);
    chk1("rstmid_busy0_async", busy0, 1'b0);
    BTN_IN = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (3) tick();
    chk1("rstmid_start_after", start1, 1'b0);
    chk1("rstmid_busy_after", busy1, 1'b0);
    chk8("rstmid_cnt_after", cnt1, 8'd0);

    // ---- Clean press: held 100 cycles, then released ----
    do_reset();
    BTN_IN = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      tick();
      chk1($sformatf("clean_start_e%0d", e), start0, e == 19);
      chk1($sformatf("clean_busy_e%0d", e), busy0, e >= 3);
      chk8($sformatf("clean_cnt_e%0d", e), cnt0, (e >= 19) ? 8'd1 : 8'd0);
    end
    BTN_IN = 1'b0;
    for (int e = 101; e <= 130; e++) begin
      tick();
      chk1($sformatf("clean_rel_busy_e%0d", e), busy0, e < 118);
      chk1($sformatf("clean_rel_start_e%0d", e), start0, 1'b0);
    end
    chk8("clean_cnt_final", cnt0, 8'd1);

    // ---- Bounce: high 10, low 1, high 30 ----
    do_reset();
    npulse = 0;
    for (int e = 1; e <= 60; e++) begin
      BTN_IN = (e <= 10) || (e >= 12 && e <= 41);
      tick();
      chk1($sformatf("bounce_start_e%0d", e), start0, e == 30);
      if (start0) npulse++;
    end
    chki("bounce_npulse", npulse, 1);
    chk8("bounce_cnt", cnt0, 8'd1);

    // ---- Hold-off / release: short release ignored, long release re-arms ----
    do_reset();
    for (int e = 1; e <= 150; e++) begin
      BTN_IN = (e <= 50) || (e >= 56 && e <= 90) || (e >= 111);
      tick();
      chk1($sformatf("holdoff_start_e%0d", e), start0, (e == 19) || (e == 129));
      if (e >= 100 && e <= 112)
        chk1($sformatf("holdoff_busy_e%0d", e), busy0, e < 108);
    end
    chk8("holdoff_cnt", cnt0, 8'd2);

    // ---- ENABLE low for the whole press ----
    do_reset();
    ENABLE = 1'b0;
    BTN_IN = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      chk1($sformatf("disabled_start_e%0d", e), start0, 1'b0);
      chk1($sformatf("disabled_busy_e%0d", e), busy0, 1'b0);
    end
    chk8("disabled_cnt", cnt0, 8'd0);

    // ---- ENABLE drop during DEBOUNCE, then re-arm with button still held ----
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      BTN_IN = 1'b1;
      ENABLE = !(e == 10 || e == 11);
      tick();
      chk1($sformatf("endrop_start_e%0d", e), start0, e == 28);
      if (e >= 9 && e <= 13)
        chk1($sformatf("endrop_busy_e%0d", e), busy0, (e == 9) || (e >= 12));
    end
    chk8("endrop_cnt", cnt0, 8'd1);

    // ---- ENABLE drop during a 4-cycle PULSE: pulse stays full width ----
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      BTN_IN = 1'b1;
      ENABLE = (e < 20);
      tick();
      chk1($sformatf("enpulse_start_e%0d", e), start1, (e >= 19) && (e <= 22));
    end
    chk8("enpulse_cnt", cnt1, 8'd1);
    ENABLE = 1'b1;

    // ---- No hold-off, 3-cycle pulse: straight to release wait ----
    do_reset();
    for (int e = 1; e <= 50; e++) begin
      BTN_IN = (e <= 20);
      tick();
      chk1($sformatf("nohold_start_e%0d", e), start2, (e >= 19) && (e <= 21));
      chk1($sformatf("nohold_busy_e%0d", e), busy2, (e >= 3) && (e < 38));
    end
    chk8("nohold_cnt", cnt2, 8'd1);

    // ---- 256 clean presses: PRESS_CNT wraps to 0 ----
    do_reset();
    npulse = 0;
    for (int p = 1; p <= 256; p++) begin
      for (int e = 1; e <= 55; e++) begin
        BTN_IN = (e <= 30);
        tick();
        if (start0) npulse++;
      end
      if (p == 1)   chk8("wrap_cnt_p1", cnt0, 8'd1);
      if (p == 255) chk8("wrap_cnt_p255", cnt0, 8'd255);
    end
    chk8("wrap_cnt_p256", cnt0, 8'd0);
    chki("wrap_npulse", npulse, 256);
    chk1("wrap_busy_idle", busy0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
